// File: rtl/ahblite_pkg.sv
// Shared AHB-Lite encodings and sizing for the slave-side response mux.
package ahblite_pkg;

  localparam int unsigned NUM_PORTS = 4;
  localparam int unsigned SEL_W     = NUM_PORTS + 1;
  localparam int unsigned SEL_DEF   = NUM_PORTS;
  localparam int unsigned DATA_W    = 32;

  typedef enum logic [1:0] {
    TRANS_IDLE   = 2'd0,
    TRANS_BUSY   = 2'd1,
    TRANS_NONSEQ = 2'd2,
    TRANS_SEQ    = 2'd3
  } htrans_e;

  typedef enum logic {
    HRESP_OKAY  = 1'b0,
    HRESP_ERROR = 1'b1
  } hresp_e;

  typedef enum logic [1:0] {
    DS_OKAY = 2'd0,
    DS_ERR1 = 2'd1,
    DS_ERR2 = 2'd2
  } ds_state_e;

endpackage

// File: rtl/ahblite_default_slave.sv
// Default slave for unmapped space: zero-wait OKAY for IDLE/BUSY,
// two-cycle ERROR response for NONSEQ/SEQ.
module ahblite_default_slave
  import ahblite_pkg::*;
(
  input  logic       HCLK,
  input  logic       HRESET,
  input  logic       HSEL_DEF,
  input  logic [1:0] HTRANS,
  input  logic       HREADY,
  output logic       HREADYOUT,
  output logic       HRESP
);

  ds_state_e state_q;
  logic      active_c;

  assign active_c = (HTRANS == TRANS_NONSEQ) || (HTRANS == TRANS_SEQ);

  // State and its outputs are registered together so the outputs never glitch.
  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      state_q   <= DS_OKAY;
      HREADYOUT <= 1'b1;
      HRESP     <= HRESP_OKAY;
    end else if (HREADY && HSEL_DEF && active_c) begin
      state_q   <= DS_ERR1;
      HREADYOUT <= 1'b0;
      HRESP     <= HRESP_ERROR;
    end else if (state_q == DS_ERR1) begin
      state_q   <= DS_ERR2;
      HREADYOUT <= 1'b1;
      HRESP     <= HRESP_ERROR;
    end else if (HREADY) begin
      state_q   <= DS_OKAY;
      HREADYOUT <= 1'b1;
      HRESP     <= HRESP_OKAY;
    end
  end

endmodule

// File: rtl/ahblite_slave_mux.sv
// AHB-Lite slave-side mux: latches the address-phase select into a data-phase
// one-hot and steers the selected slave's ready/data/response to the master.
module ahblite_slave_mux
  import ahblite_pkg::*;
#(
  parameter bit Port0_en = 1'b1,
  parameter bit Port1_en = 1'b1,
  parameter bit Port2_en = 1'b1,
  parameter bit Port3_en = 1'b1
) (
  input  logic              HCLK,
  input  logic              HRESET,
  output logic              HREADY,
  input  logic [1:0]        HTRANS,
  input  logic              P0_HSEL,
  input  logic              P1_HSEL,
  input  logic              P2_HSEL,
  input  logic              P3_HSEL,
  input  logic              P0_HREADYOUT,
  input  logic              P1_HREADYOUT,
  input  logic              P2_HREADYOUT,
  input  logic              P3_HREADYOUT,
  input  logic [DATA_W-1:0] P0_HRDATA,
  input  logic [DATA_W-1:0] P1_HRDATA,
  input  logic [DATA_W-1:0] P2_HRDATA,
  input  logic [DATA_W-1:0] P3_HRDATA,
  input  logic              P0_HRESP,
  input  logic              P1_HRESP,
  input  logic              P2_HRESP,
  input  logic              P3_HRESP,
  output logic [DATA_W-1:0] HRDATA,
  output logic              HRESP
);

  localparam logic [NUM_PORTS-1:0] PORT_EN = {Port3_en, Port2_en, Port1_en, Port0_en};
  localparam logic [SEL_W-1:0]     SEL_RST = {1'b1, {NUM_PORTS{1'b0}}};

  logic [NUM_PORTS-1:0] hsel_en_c;
  logic [NUM_PORTS-1:0] hreadyout_v;
  logic [NUM_PORTS-1:0] hresp_v;
  logic [DATA_W-1:0]    hrdata_v [NUM_PORTS];
  logic [SEL_W-1:0]     sel_d_c;
  logic [SEL_W-1:0]     sel_q;
  logic                 hsel_def_c;
  logic                 ds_hreadyout;
  logic                 ds_hresp;

  assign hsel_en_c   = {P3_HSEL, P2_HSEL, P1_HSEL, P0_HSEL} & PORT_EN;
  assign hreadyout_v = {P3_HREADYOUT, P2_HREADYOUT, P1_HREADYOUT, P0_HREADYOUT};
  assign hresp_v     = {P3_HRESP, P2_HRESP, P1_HRESP, P0_HRESP};
  assign hrdata_v[0] = P0_HRDATA;
  assign hrdata_v[1] = P1_HRDATA;
  assign hrdata_v[2] = P2_HRDATA;
  assign hrdata_v[3] = P3_HRDATA;
  assign hsel_def_c  = ~|hsel_en_c;

  // Lowest-numbered enabled select wins; scanning downward lets it overwrite.
  always_comb begin
    sel_d_c = SEL_RST;
    for (int i = NUM_PORTS - 1; i >= 0; i--) begin
      if (hsel_en_c[i]) begin
        sel_d_c    = '0;
        sel_d_c[i] = 1'b1;
      end
    end
  end

  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      sel_q <= SEL_RST;
    end else if (HREADY) begin
      sel_q <= sel_d_c;
    end
  end

  // Data-phase response mux; falls through to the default slave.
  always_comb begin
    HREADY = ds_hreadyout;
    HRESP  = ds_hresp;
    HRDATA = '0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      if (sel_q[i] && PORT_EN[i]) begin
        HREADY = hreadyout_v[i];
        HRESP  = hresp_v[i];
        HRDATA = hrdata_v[i];
      end
    end
  end

  ahblite_default_slave u_default_slave (
    .HCLK      (HCLK),
    .HRESET    (HRESET),
    .HSEL_DEF  (hsel_def_c),
    .HTRANS    (HTRANS),
    .HREADY    (HREADY),
    .HREADYOUT (ds_hreadyout),
    .HRESP     (ds_hresp)
  );

endmodule

// File: doc/ahblite_slave_mux.md
AHBLITE_SLAVE_MUX -- requirements
Module: ahblite_slave_mux

Interface
REQ-001 SHALL have parameters Port0_en, Port1_en, Port2_en, Port3_en, each default 1, meaning the port is implemented; a 0 port is never selected and its inputs are ignored.
REQ-002 SHALL have ports, in order:
- HCLK  in  1  system clock.
- HRESET  in  1  reset.
- HREADY  out  1  merged ready to the master; also fed back internally as the address-phase qualifier.
- HTRANS  in  2  master transfer type.
- Px_HSEL  in  1 each (x=0..3)  address-phase selects from the address decoder.
- Px_HREADYOUT  in  1 each  slave ready.
- Px_HRDATA  in  32 each  slave read data.
- Px_HRESP  in  1 each  slave response: 0=OKAY, 1=ERROR.
- HRDATA  out  32  muxed read data.
- HRESP  out  1  muxed response.
REQ-003 SHALL use one clock, HCLK; reset HRESET is asynchronous and active-high.

Function
REQ-004 SHALL hold a data-phase select register sel_q, one-hot over {P0, P1, P2, P3, DEF}.
REQ-005 SHALL load sel_q on a rising HCLK edge only when HREADY=1; otherwise sel_q holds.
REQ-006 SHALL compute the load value with priority P0>P1>P2>P3, gated by Portx_en; DEF is selected when no enabled HSEL is asserted.
REQ-007 When sel_q=Px, HREADY, HRDATA and HRESP SHALL equal Px_HREADYOUT, Px_HRDATA and Px_HRESP combinationally, with zero added latency.
REQ-008 When sel_q=DEF, the outputs SHALL come from the default slave: HRDATA=0 always.
REQ-009 The default-slave FSM SHALL have states OKAY, ERR1 and ERR2.
REQ-010 OKAY state SHALL drive HREADY=1, HRESP=0.
REQ-011 ERR1 state SHALL drive HREADY=0, HRESP=1.
REQ-012 ERR2 state SHALL drive HREADY=1, HRESP=1.
REQ-013 FSM transitions SHALL be:
- OKAY/ERR2 -> ERR1 when HREADY=1, no enabled HSEL and HTRANS[1]=1 (NONSEQ or SEQ).
- ERR1 -> ERR2 unconditionally.
- otherwise -> OKAY when HREADY=1.
REQ-014 IDLE or BUSY transfers to unmapped space SHALL complete zero-wait with OKAY.
REQ-015 A new address phase accepted in the ERR2 cycle (HREADY=1) SHALL be decoded normally, giving back-to-back error or slave transfers with no gap cycle.
REQ-016 A slave holding Px_HREADYOUT=0 SHALL stall indefinitely, with sel_q frozen; HSEL changes during the stall are ignored.
REQ-017 Simultaneous multiple HSEL SHALL resolve per REQ-006, with no error generated.

Reset
REQ-018 On HRESET=1, sel_q SHALL be set to DEF and the FSM to OKAY, so that HREADY=1, HRESP=0 and HRDATA=0 are driven during reset and until the first transfer.
REQ-019 Reset asserted mid-transfer, including in ERR1, SHALL abort the transfer immediately and asynchronously; after reset the outputs are the REQ-018 values.

Structure
REQ-020 Shared package ahblite_pkg SHALL contain:
- HTRANS encodings: IDLE=0, BUSY=1, NONSEQ=2, SEQ=3.
- HRESP encodings.
- the default-slave state enum.
- the constant NUM_PORTS=4.
REQ-021 The default slave SHALL be a sub-module, ahblite_default_slave, with inputs HCLK, HRESET, HSEL_DEF, HTRANS and HREADY, and outputs HREADYOUT and HRESP.

Verification
REQ-022 Reset release, no traffic -> HREADY=1, HRESP=0, HRDATA=0x00000000.
REQ-023 P1_HSEL=1 with NONSEQ, then P1_HRDATA=0xDEADBEEF with P1_HREADYOUT low for 3 cycles -> HREADY low for 3 cycles, then HRDATA=0xDEADBEEF with HREADY=1 and HRESP=0.
REQ-024 NONSEQ to unmapped address (all HSEL=0) -> next cycle HREADY=0 and HRESP=1, following cycle HREADY=1 and HRESP=1, then OKAY.
REQ-025 Two back-to-back unmapped NONSEQ transfers -> ERR1, ERR2, ERR1, ERR2, with the second address accepted on the first ERR2 cycle.
REQ-026 Port2_en=0, P2_HSEL=1 with SEQ -> two-cycle ERROR response, and P2 inputs never reach the outputs.
REQ-027 HRESET pulsed during ERR1 -> HREADY=1 and HRESP=0 immediately, without waiting for a clock edge.
